// File: rtl/ae_pkg.sv
// Shared definitions for the autoencoder training sequencer and its sample memory.
// Holds the sequencer state encoding and the default dataset/epoch sizes.
package ae_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int AE_N_SAMPLES = 332;
  localparam int AE_N_ITER    = 10000;

  // Bits needed to hold the value v (at least one bit).
  function automatic int width_for(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/train_seq_ctrl_sample_idx_counter.sv
// Modulo-N sample index counter: clr forces 0, inc advances and wraps N-1 -> 0.
// wrap is high while the index sits on its last value.
module sample_idx_counter #(
  parameter int N = 332,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] idx,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign wrap = (idx == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= wrap ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/train_seq_ctrl.sv
// Training-loop sequencer: issues sample addresses 0..N_SAMPLES-1 per epoch for N_ITER epochs.
// Optional WAIT-state watchdog enabled by defining TRAIN_SEQ_WDT_EN.
module train_seq_ctrl
  import ae_pkg::*;
#(
  parameter int N_SAMPLES   = AE_N_SAMPLES,
  parameter int N_ITER      = AE_N_ITER,
  parameter int ADDR_W      = 16,
  parameter int ITER_W      = 17,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              sample_ready,
  input  logic              sample_done,
  output logic              sample_valid,
  output logic [ADDR_W-1:0] sample_addr,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              epoch_end,
  output logic              busy,
  output logic              train_done,
  output logic              timeout_err
);

  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N_ITER - 1);
  localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(N_ITER);

  seq_state_e state, next_state;

  logic idx_clr, idx_inc, idx_last;
  logic iter_clr, iter_inc;
  logic epoch_set;
  logic wdt_clr, wdt_fire, err_clr;

  sample_idx_counter #(
    .N (N_SAMPLES),
    .W (ADDR_W)
  ) u_idx (
    .clk  (clk),
    .rst  (rst),
    .clr  (idx_clr),
    .inc  (idx_inc),
    .idx  (sample_addr),
    .wrap (idx_last)
  );

`ifdef TRAIN_SEQ_WDT_EN
  localparam int WDT_W = width_for(TIMEOUT_CYC);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT_CYC - 1);
  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_hit;

  assign wdt_hit = (wdt_cnt == WDT_LAST);
`else
  logic unused_wdt_cfg;
  logic wdt_hit;

  assign unused_wdt_cfg = (TIMEOUT_CYC > 0);
  assign wdt_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // abort outranks every other input; sample_done is consulted only in WAIT.
  always_comb begin
    next_state = state;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    iter_clr   = 1'b0;
    iter_inc   = 1'b0;
    epoch_set  = 1'b0;
    wdt_clr    = 1'b0;
    wdt_fire   = 1'b0;
    err_clr    = 1'b0;
    if (abort) begin
      next_state = ST_IDLE;
      idx_clr    = 1'b1;
      iter_clr   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            next_state = ST_ISSUE;
            idx_clr    = 1'b1;
            iter_clr   = 1'b1;
            err_clr    = 1'b1;
          end
        end
        ST_ISSUE: begin
          if (sample_ready) begin
            next_state = ST_WAIT;
            wdt_clr    = 1'b1;
          end
        end
        ST_WAIT: begin
          if (sample_done) begin
            idx_inc = 1'b1;
            if (idx_last) begin
              iter_inc   = 1'b1;
              epoch_set  = 1'b1;
              next_state = (iter_cnt == ITER_LAST) ? ST_DONE : ST_ISSUE;
            end else begin
              next_state = ST_ISSUE;
            end
          end else if (wdt_hit) begin
            next_state = ST_IDLE;
            wdt_fire   = 1'b1;
            idx_clr    = 1'b1;
            iter_clr   = 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            next_state = ST_ISSUE;
            idx_clr    = 1'b1;
            iter_clr   = 1'b1;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Epoch counter saturates at N_ITER so it can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst || iter_clr) begin
      iter_cnt <= '0;
    end else if (iter_inc && (iter_cnt != ITER_MAX)) begin
      iter_cnt <= iter_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_end <= 1'b0;
    end else begin
      epoch_end <= epoch_set;
    end
  end

`ifdef TRAIN_SEQ_WDT_EN
  always_ff @(posedge clk) begin
    if (rst || wdt_clr) begin
      wdt_cnt <= '0;
    end else if (state == ST_WAIT && !wdt_hit) begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end

  // Sticky until reset or a fresh start from IDLE.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      timeout_err <= 1'b0;
    end else if (wdt_fire) begin
      timeout_err <= 1'b1;
    end
  end
`else
  logic unused_wdt_ctl;

  assign unused_wdt_ctl = wdt_clr | wdt_fire | err_clr;
  assign timeout_err    = 1'b0;
`endif

  assign sample_valid = (state == ST_ISSUE);
  assign busy         = (state == ST_ISSUE) || (state == ST_WAIT);
  assign train_done   = (state == ST_DONE);

endmodule

// File: tb/tb_train_seq_ctrl.sv
// Directed plus randomized bench for train_seq_ctrl with N_SAMPLES=4, N_ITER=3, TIMEOUT_CYC=8.
// Watchdog scenario is compiled only when TRAIN_SEQ_WDT_EN is defined.
module tb_train_seq_ctrl;

  localparam int NS = 4;
  localparam int NI = 3;
  localparam int TO = 8;
  localparam int AW = 16;
  localparam int IW = 17;

  logic          clk = 1'b0;
  logic          rst, start, abort, sample_ready, sample_done;
  logic          sample_valid, epoch_end, busy, train_done, timeout_err;
  logic [AW-1:0] sample_addr;
  logic [IW-1:0] iter_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: phase flags, counters and cycles spent waiting.
  bit m_issue, m_wait, m_done, m_err, m_ep;
  int m_addr, m_iter, m_wage;

  int epochs_seen;
  int hs_q[$];

  always #5 clk = ~clk;

  train_seq_ctrl #(
    .N_SAMPLES   (NS),
    .N_ITER      (NI),
    .ADDR_W      (AW),
    .ITER_W      (IW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .sample_ready (sample_ready),
    .sample_done  (sample_done),
    .sample_valid (sample_valid),
    .sample_addr  (sample_addr),
    .iter_cnt     (iter_cnt),
    .epoch_end    (epoch_end),
    .busy         (busy),
    .train_done   (train_done),
    .timeout_err  (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_issue = 0; m_wait = 0; m_done = 0; m_ep = 0;
    m_addr  = 0; m_iter = 0; m_wage = 0;
  endtask

  task automatic model_step(input bit s, input bit a, input bit r, input bit d);
    m_ep = 0;
    if (a) begin
      m_issue = 0; m_wait = 0; m_done = 0;
      m_addr = 0; m_iter = 0;
    end else if (m_issue) begin
      if (r) begin
        m_issue = 0; m_wait = 1; m_wage = 0;
      end
    end else if (m_wait) begin
      if (d) begin
        m_wait = 0;
        if (m_addr == NS - 1) begin
          m_addr = 0;
          if (m_iter < NI) m_iter++;
          m_ep = 1;
          if (m_iter == NI) m_done = 1;
          else m_issue = 1;
        end else begin
          m_addr++;
          m_issue = 1;
        end
      end else begin
        m_wage++;
`ifdef TRAIN_SEQ_WDT_EN
        if (m_wage == TO) begin
          m_err = 1; m_wait = 0; m_addr = 0; m_iter = 0;
        end
`endif
      end
    end else if (s) begin
      if (!m_done) m_err = 0;
      m_done = 0; m_issue = 1; m_addr = 0; m_iter = 0;
    end
  endtask

  task automatic check_outputs();
    check("sample_valid", sample_valid, m_issue);
    check("sample_addr", sample_addr, m_addr);
    check("iter_cnt", iter_cnt, m_iter);
    check("epoch_end", epoch_end, m_ep);
    check("busy", busy, m_issue | m_wait);
    check("train_done", train_done, m_done);
    check("timeout_err", timeout_err, m_err);
  endtask

  task automatic do_reset();
    rst = 1; start = 0; abort = 0; sample_ready = 0; sample_done = 0;
    model_clear();
    m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 0;
  endtask

  task automatic step(input bit s, input bit a, input bit r, input bit d);
    start = s; abort = a; sample_ready = r; sample_done = d;
    if (sample_valid === 1'b1 && r && !a) hs_q.push_back(int'(sample_addr));
    model_step(s, a, r, d);
    @(posedge clk);
    #1;
    if (epoch_end === 1'b1) epochs_seen++;
    check_outputs();
  endtask

  // Always ready; sample_done two cycles after each handshake.
  task automatic auto_step();
    step(1'b0, 1'b0, 1'b1, m_wait && (m_wage >= 1));
  endtask

  initial begin
    logic [AW-1:0] held_addr;
    int n;

    // Reset state
    do_reset();

    // Full run: 3 epochs of 4 samples
    hs_q.delete();
    epochs_seen = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!m_done && n < 200) begin
      auto_step();
      n++;
    end
    check("run_train_done", train_done, 1);
    check("run_iter_cnt", iter_cnt, NI);
    check("run_epochs", epochs_seen, NI);
    check("run_handshakes", hs_q.size(), NS * NI);
    for (int i = 0; i < hs_q.size() && i < NS * NI; i++)
      check("run_addr_seq", hs_q[i], i % NS);

    // DONE holds; then restart
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("done_hold_iter", iter_cnt, NI);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_addr", sample_addr, 0);
    check("restart_iter", iter_cnt, 0);
    check("restart_done", train_done, 0);
    check("restart_valid", sample_valid, 1);

    // Back-pressure in ISSUE
    held_addr = sample_addr;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("bp_valid", sample_valid, 1);
      check("bp_addr", sample_addr, held_addr);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_wait_valid", sample_valid, 0);
    check("bp_wait_busy", busy, 1);

    // Spurious start in WAIT, then spurious sample_done in ISSUE
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("sp_start_addr", sample_addr, 0);
    check("sp_start_valid", sample_valid, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("sp_adv_addr", sample_addr, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("sp_done_addr", sample_addr, 1);
    check("sp_done_valid", sample_valid, 1);

    // Abort together with sample_done at addr=2, iter=1
    n = 0;
    while (!(m_wait && m_addr == 2 && m_iter == 1) && n < 200) begin
      auto_step();
      n++;
    end
    check("ab_setup_addr", sample_addr, 2);
    check("ab_setup_iter", iter_cnt, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("ab_addr", sample_addr, 0);
    check("ab_iter", iter_cnt, 0);
    check("ab_busy", busy, 0);
    check("ab_epoch_end", epoch_end, 0);

    // Abort at the last sample of an epoch must not pulse epoch_end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!(m_wait && m_addr == NS - 1) && n < 50) begin
      auto_step();
      n++;
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("ab_last_epoch_end", epoch_end, 0);
    check("ab_last_iter", iter_cnt, 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 8) == 0, ($urandom % 60) == 0,
           ($urandom % 4) != 0, ($urandom % 3) == 0);
    end

`ifdef TRAIN_SEQ_WDT_EN
    // Watchdog: no sample_done ever arrives
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < TO - 1; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("wdt_early", timeout_err, 0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("wdt_err", timeout_err, 1);
    check("wdt_idle_busy", busy, 0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
    check("wdt_sticky", timeout_err, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("wdt_cleared", timeout_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
